// File: rtl/scandoubler_vid_sched_pkg.sv
// -----------------------------------------------------------------------------
// scandoubler_pkg
// Shared definitions for the scandoubler SDRAM video scheduler:
//   BURST_LEN / HALF_WORDS - burst length and ping-pong half size (8 words)
//   DATA_W                 - pixel word width
//   coord_t                - 11-bit row/column coordinate
//   wr_state_e, rd_state_e - write and read FSM state encodings
//   burst_count()          - number of 8-word bursts covering a line width
// -----------------------------------------------------------------------------
package scandoubler_pkg;

  localparam int BURST_LEN  = 8;
  localparam int HALF_WORDS = 8;
  localparam int DATA_W     = 16;

  typedef logic [10:0] coord_t;

  typedef enum logic {
    WR_IDLE  = 1'b0,
    WR_BURST = 1'b1
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_BURST = 2'd1,
    RD_NEXT  = 2'd2
  } rd_state_e;

  // ceil(width / 8); a full 2047-pixel line needs 256 bursts, hence 9 bits.
  function automatic logic [8:0] burst_count(input coord_t width);
    return 9'(({1'b0, width} + 12'd7) >> 3);
  endfunction

endpackage

// File: rtl/scandoubler_vid_sched_if.sv
// -----------------------------------------------------------------------------
// scandoubler_vid_sched_if
// SDRAM-side write and read burst ports of the scandoubler scheduler.
//   Write port : vidin_req/frame/row/col/d (scheduler -> SDRAM), vidin_ack back
//   Read port  : vidout_req/frame/row/col (scheduler -> SDRAM),
//                vidout_q/vidout_ack back
// modport master : the scheduler
// modport slave  : the SDRAM controller
// -----------------------------------------------------------------------------
interface scandoubler_vid_sched_if;

  logic                   vidin_req;
  logic [1:0]             vidin_frame;
  scandoubler_pkg::coord_t vidin_row;
  scandoubler_pkg::coord_t vidin_col;
  logic [15:0]            vidin_d;
  logic                   vidin_ack;

  logic                   vidout_req;
  logic [1:0]             vidout_frame;
  scandoubler_pkg::coord_t vidout_row;
  scandoubler_pkg::coord_t vidout_col;
  logic [15:0]            vidout_q;
  logic                   vidout_ack;

  modport master (
    output vidin_req, vidin_frame, vidin_row, vidin_col, vidin_d,
    input  vidin_ack,
    output vidout_req, vidout_frame, vidout_row, vidout_col,
    input  vidout_q, vidout_ack
  );

  modport slave (
    input  vidin_req, vidin_frame, vidin_row, vidin_col, vidin_d,
    output vidin_ack,
    input  vidout_req, vidout_frame, vidout_row, vidout_col,
    output vidout_q, vidout_ack
  );

endinterface

// File: rtl/scandoubler_pingpong_buf.sv
// -----------------------------------------------------------------------------
// scandoubler_pingpong_buf
// Two 8-word halves of 16-bit pixel storage. The fill side writes words in
// order; a half becomes ready when full or when flushed part-way. The transfer
// side walks the halves in the same order, marking a half busy while its burst
// is on the bus. Words past a flushed half's fill length read back as 0.
// Ports:
//   clk_96, init_n        clock, async active-low reset
//   wr_en, wr_d           pixel write request and data
//   flush                 close a partially filled half
//   tx_start, tx_done     transfer of half tx_half begins / ends
//   rd_idx, rd_d          word index within tx_half and its data
//   wr_ok, wr_drop        write accepted / dropped (fill half occupied)
//   fill_half, fill_idx   current fill position
//   tx_half, tx_ready     next half to transfer and whether it is ready
// -----------------------------------------------------------------------------
module scandoubler_pingpong_buf
  import scandoubler_pkg::*;
(
  input  logic              clk_96,
  input  logic              init_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_d,
  input  logic              flush,
  input  logic              tx_start,
  input  logic              tx_done,
  input  logic [2:0]        rd_idx,
  output logic              wr_ok,
  output logic              wr_drop,
  output logic              fill_half,
  output logic [2:0]        fill_idx,
  output logic              tx_half,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rd_d
);

  logic [DATA_W-1:0] store [2*HALF_WORDS];
  logic [1:0]        ready;
  logic [1:0]        busy;
  logic [3:0]        len [2];
  logic              fill_occupied;

  // Halves fill alternately, so an occupied fill half means both are taken.
  assign fill_occupied = ready[fill_half] | busy[fill_half];
  assign wr_ok         = wr_en & ~fill_occupied;
  assign wr_drop       = wr_en &  fill_occupied;
  assign tx_ready      = ready[tx_half];
  assign rd_d          = ({1'b0, rd_idx} < len[tx_half]) ? store[{tx_half, rd_idx}] : '0;

  always_ff @(posedge clk_96 or negedge init_n) begin
    if (!init_n) begin
      for (int i = 0; i < 2*HALF_WORDS; i++) store[4'(i)] <= '0;
      ready     <= '0;
      busy      <= '0;
      len[0]    <= '0;
      len[1]    <= '0;
      fill_half <= 1'b0;
      fill_idx  <= '0;
      tx_half   <= 1'b0;
    end else begin
      if (wr_ok) begin
        store[{fill_half, fill_idx}] <= wr_d;
        if (fill_idx == 3'(HALF_WORDS-1)) begin
          ready[fill_half] <= 1'b1;
          len[fill_half]   <= 4'(HALF_WORDS);
          fill_half        <= ~fill_half;
          fill_idx         <= '0;
        end else begin
          fill_idx <= fill_idx + 3'd1;
        end
      end else if (flush && fill_idx != 3'd0) begin
        ready[fill_half] <= 1'b1;
        len[fill_half]   <= {1'b0, fill_idx};
        fill_half        <= ~fill_half;
        fill_idx         <= '0;
      end
      // Transfer updates always target the other (occupied) half from fill.
      if (tx_start) begin
        ready[tx_half] <= 1'b0;
        busy[tx_half]  <= 1'b1;
      end
      if (tx_done) begin
        busy[tx_half] <= 1'b0;
        tx_half       <= ~tx_half;
      end
    end
  end

endmodule

// File: rtl/scandoubler_vid_sched.sv
// -----------------------------------------------------------------------------
// scandoubler_vid_sched
// SDRAM scheduler for a scandoubler. Input pixels are gathered into a
// ping-pong buffer and written to SDRAM in 8-word bursts; on each output line
// start the line is read back in 8-word bursts into a line buffer.
// Ports:
//   clk_96, init_n                 96 MHz SDRAM clock, async active-low reset
//   pix_we, pix_d, in_hs, in_vs    input pixel strobe/data, line/frame start
//   sdram (master modport)         write and read burst ports
//   out_hs, out_row, out_width     output line start, line to fetch, width
//   lb_we, lb_addr, lb_d           line buffer write port
//   ovf                            sticky overflow (input word dropped)
//   ovf_cnt                        saturating dropped-word count, present only
//                                  when SD_SCHED_OVF_CNT_EN is defined
// -----------------------------------------------------------------------------
module scandoubler_vid_sched
  import scandoubler_pkg::*;
(
  input  logic                     clk_96,
  input  logic                     init_n,
  input  logic                     pix_we,
  input  logic [15:0]              pix_d,
  input  logic                     in_hs,
  input  logic                     in_vs,
  scandoubler_vid_sched_if.master  sdram,
  input  logic                     out_hs,
  input  coord_t                   out_row,
  input  coord_t                   out_width,
  output logic                     lb_we,
  output coord_t                   lb_addr,
  output logic [15:0]              lb_d,
  output logic                     ovf
`ifdef SD_SCHED_OVF_CNT_EN
  ,
  output logic [7:0]               ovf_cnt
`endif
);

  // Input side
  coord_t      x;
  coord_t      in_row;
  logic [1:0]  done_frame;
  coord_t      hcol [2];
  coord_t      hrow [2];

  // Ping-pong buffer handshake
  logic        buf_wr_en;
  logic        buf_wr_ok;
  logic        buf_drop;
  logic        fill_half;
  logic [2:0]  fill_idx;
  logic        tx_half;
  logic        tx_ready;
  logic        tx_start;
  logic        tx_done;
  logic [2:0]  rd_idx;
  logic [15:0] buf_rd_d;

  // Write FSM
  wr_state_e   wr_state;
  logic [2:0]  wr_cnt;

  // Read FSM
  rd_state_e   rd_state;
  logic [2:0]  rd_cnt;
  logic [8:0]  bursts_left;
  logic        pend;
  coord_t      pend_row;
  coord_t      pend_width;
  logic [1:0]  pend_frame;
  logic        rd_start;
  coord_t      src_row;
  coord_t      src_width;
  logic [1:0]  src_frame;

  // Line and frame starts take priority over a coincident pixel.
  assign buf_wr_en = pix_we & ~in_hs & ~in_vs;
  assign tx_start  = (wr_state == WR_IDLE) & tx_ready;
  assign tx_done   = (wr_state == WR_BURST) & sdram.vidin_ack & (wr_cnt == 3'(BURST_LEN-1));
  // Prefetch the word the bus will want after the next ack.
  assign rd_idx    = (wr_state == WR_IDLE) ? 3'd0 : wr_cnt + 3'd1;

  scandoubler_pingpong_buf u_buf (
    .clk_96    (clk_96),
    .init_n    (init_n),
    .wr_en     (buf_wr_en),
    .wr_d      (pix_d),
    .flush     (in_hs & ~in_vs),
    .tx_start  (tx_start),
    .tx_done   (tx_done),
    .rd_idx    (rd_idx),
    .wr_ok     (buf_wr_ok),
    .wr_drop   (buf_drop),
    .fill_half (fill_half),
    .fill_idx  (fill_idx),
    .tx_half   (tx_half),
    .tx_ready  (tx_ready),
    .rd_d      (buf_rd_d)
  );

  // Input position tracking and per-half burst address capture
  always_ff @(posedge clk_96 or negedge init_n) begin
    if (!init_n) begin
      x                 <= '0;
      in_row            <= '0;
      sdram.vidin_frame <= '0;
      done_frame        <= '0;
      hcol[0]           <= '0;
      hcol[1]           <= '0;
      hrow[0]           <= '0;
      hrow[1]           <= '0;
      ovf               <= 1'b0;
    end else begin
      if (in_vs) begin
        in_row            <= '0;
        x                 <= '0;
        done_frame        <= sdram.vidin_frame;
        sdram.vidin_frame <= sdram.vidin_frame + 2'd1;
      end else if (in_hs) begin
        in_row <= in_row + 11'd1;
        x      <= '0;
      end else if (pix_we) begin
        // A dropped pixel still occupies its screen position.
        x <= x + 11'd1;
        if (buf_wr_ok && fill_idx == 3'd0) begin
          hcol[fill_half] <= x;
          hrow[fill_half] <= in_row;
        end
      end
      if (buf_drop) ovf <= 1'b1;
    end
  end

`ifdef SD_SCHED_OVF_CNT_EN
  always_ff @(posedge clk_96 or negedge init_n) begin
    if (!init_n) begin
      ovf_cnt <= '0;
    end else if (buf_drop && ovf_cnt != 8'hFF) begin
      ovf_cnt <= ovf_cnt + 8'd1;
    end
  end
`endif

  // Write FSM: one burst per ready half
  always_ff @(posedge clk_96 or negedge init_n) begin
    if (!init_n) begin
      wr_state        <= WR_IDLE;
      wr_cnt          <= '0;
      sdram.vidin_req <= 1'b0;
      sdram.vidin_row <= '0;
      sdram.vidin_col <= '0;
      sdram.vidin_d   <= '0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (tx_ready) begin
            wr_state        <= WR_BURST;
            wr_cnt          <= '0;
            sdram.vidin_req <= 1'b1;
            sdram.vidin_row <= hrow[tx_half];
            sdram.vidin_col <= hcol[tx_half];
            sdram.vidin_d   <= buf_rd_d;
          end
        end
        WR_BURST: begin
          if (sdram.vidin_ack) begin
            if (wr_cnt == 3'(BURST_LEN-1)) begin
              wr_state        <= WR_IDLE;
              sdram.vidin_req <= 1'b0;
            end else begin
              wr_cnt        <= wr_cnt + 3'd1;
              sdram.vidin_d <= buf_rd_d;
            end
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // A new line comes either from out_hs now or from one that arrived mid-burst.
  always_comb begin
    if (out_hs) begin
      src_row   = out_row;
      src_width = out_width;
      src_frame = done_frame;
    end else begin
      src_row   = pend_row;
      src_width = pend_width;
      src_frame = pend_frame;
    end
  end

  assign rd_start = ((rd_state == RD_IDLE) && out_hs) ||
                    ((rd_state == RD_NEXT) && (out_hs || pend));

  // Read FSM: fetch a line as consecutive bursts into the line buffer
  always_ff @(posedge clk_96 or negedge init_n) begin
    if (!init_n) begin
      rd_state           <= RD_IDLE;
      rd_cnt             <= '0;
      bursts_left        <= '0;
      pend               <= 1'b0;
      pend_row           <= '0;
      pend_width         <= '0;
      pend_frame         <= '0;
      sdram.vidout_req   <= 1'b0;
      sdram.vidout_frame <= '0;
      sdram.vidout_row   <= '0;
      sdram.vidout_col   <= '0;
      lb_we              <= 1'b0;
      lb_addr            <= '0;
      lb_d               <= '0;
    end else begin
      lb_we <= 1'b0;
      if (rd_start) begin
        pend <= 1'b0;
        if (src_width != 11'd0) begin
          rd_state           <= RD_BURST;
          rd_cnt             <= '0;
          bursts_left        <= burst_count(src_width);
          sdram.vidout_req   <= 1'b1;
          sdram.vidout_row   <= src_row;
          sdram.vidout_frame <= src_frame;
          sdram.vidout_col   <= '0;
        end else begin
          rd_state <= RD_IDLE;
        end
      end else if (rd_state == RD_BURST) begin
        // The burst on the bus always completes; a new line waits for it.
        if (out_hs) begin
          pend       <= 1'b1;
          pend_row   <= out_row;
          pend_width <= out_width;
          pend_frame <= done_frame;
        end
        if (sdram.vidout_ack) begin
          lb_we   <= 1'b1;
          lb_d    <= sdram.vidout_q;
          lb_addr <= sdram.vidout_col + {8'd0, rd_cnt};
          rd_cnt  <= rd_cnt + 3'd1;
          if (rd_cnt == 3'(BURST_LEN-1)) begin
            sdram.vidout_req <= 1'b0;
            rd_state         <= RD_NEXT;
          end
        end
      end else if (rd_state == RD_NEXT) begin
        if (bursts_left > 9'd1) begin
          bursts_left      <= bursts_left - 9'd1;
          sdram.vidout_col <= sdram.vidout_col + 11'(BURST_LEN);
          sdram.vidout_req <= 1'b1;
          rd_state         <= RD_BURST;
        end else begin
          rd_state <= RD_IDLE;
        end
      end
    end
  end

endmodule

// File: doc/scandoubler_vid_sched.md
SCANDOUBLER_VID_SCHED -- requirements
Module: scandoubler_vid_sched

Interface
REQ-001 SHALL have ports: clk_96 in 1, the 96 MHz SDRAM clock; init_n in 1, reset; asynchronous and active-low.
REQ-002 SHALL have input-side ports: pix_we in 1, input pixel strobe; pix_d in 16, pixel word; in_hs in 1, input line-start pulse; in_vs in 1, input frame-start pulse.
REQ-003 SHALL have write-port ports: vidin_req out 1; vidin_frame out 2; vidin_row out 11; vidin_col out 11; vidin_d out 16; vidin_ack in 1, one pulse per word taken.
REQ-004 SHALL have read-port ports: vidout_req out 1; vidout_frame out 2; vidout_row out 11; vidout_col out 11; vidout_q in 16; vidout_ack in 1, one pulse per word valid.
REQ-005 SHALL have output-side ports: out_hs in 1, output line-start pulse; out_row in 11, output line to fetch; out_width in 11, pixels per line; lb_we out 1; lb_addr out 11; lb_d out 16; ovf out 1, sticky overflow flag.

Function
REQ-006 SHALL fix the burst length at BURST_LEN = 8 words for both write and read bursts.
REQ-007 SHALL buffer input pixels in a ping-pong store of 2 halves x 8 words; pix_we writes pix_d at the fill pointer and advances it.
REQ-008 SHALL mark a half ready when its 8th word is written; a ready half SHALL raise vidin_req on the next cycle, with vidin_col = the x of the half's first pixel and vidin_row = in_row.
REQ-009 SHALL present word k of the active half on vidin_d in the cycle after the k-th vidin_ack (k = 0 before any ack); vidin_req SHALL drop in the cycle after the 8th ack.
REQ-010 SHALL handle in_hs as follows: flush a partially filled half with its missing words written as 0; then in_row += 1 and x = 0.
REQ-011 SHALL handle in_vs as follows: in_row = 0, x = 0, vidin_frame += 1 (mod 4); the frame that just completed SHALL be latched as done_frame.
REQ-012 SHALL, when pix_we arrives while both halves are ready or in transfer, drop the word and set ovf; ovf SHALL clear only on reset.
REQ-013 SHALL use write FSM states WR_IDLE -> WR_BURST (on a ready half) -> WR_IDLE after 8 acks; a second ready half SHALL start in the next cycle.
REQ-014 SHALL use read FSM states RD_IDLE -> RD_BURST (on out_hs; latch out_row, bursts = ceil(out_width/8), vidout_col = 0) -> RD_NEXT after 8 acks -> RD_BURST with col += 8, or RD_IDLE when all bursts are done.
REQ-015 SHALL drive vidout_frame = done_frame, latched at out_hs and constant for the whole line.
REQ-016 SHALL, on each vidout_ack, set lb_we = 1 for one cycle next cycle, with lb_d = vidout_q and lb_addr = vidout_col + word index.
REQ-017 SHALL, when out_hs arrives while not in RD_IDLE, abort the remaining bursts after the current burst's 8 acks and restart with the new line.
REQ-018 SHALL, when out_width = 0, issue no request.
REQ-019 SHALL allow vidin_req and vidout_req to be high together; the SDRAM side grants the write first, and the two FSMs SHALL remain independent.

Reset
REQ-020 SHALL, while init_n = 0, asynchronously clear all state: FSMs to WR_IDLE/RD_IDLE; pointers, in_row, x and frames to 0; vidin_req, vidout_req, lb_we and ovf to 0; vidin_d, lb_d and lb_addr to 0.
REQ-021 SHALL discard a burst that is in progress when reset asserts; acks arriving after release while in idle SHALL be ignored.

Configuration
REQ-022 SHALL, with SD_SCHED_OVF_CNT_EN defined, add port ovf_cnt out 8: a saturating count of dropped words (255 max) that clears on reset.
REQ-023 SHALL, without SD_SCHED_OVF_CNT_EN, omit the ovf_cnt port and keep only the ovf flag.

Structure
REQ-024 SHALL place BURST_LEN, HALF_WORDS = 8, the write FSM and read FSM state enums, and the 11-bit coordinate type in a shared package, scandoubler_pkg.
REQ-025 SHALL implement the ping-pong store as one sub-module, scandoubler_pingpong_buf: 16x16 storage with ready and busy flags per half.

Verification
REQ-026 SHALL cover: 8 pix_we of 0x1000..0x1007 at row 5, x 0 -> vidin_req with row 5, col 0; vidin_d sequence 0x1000..0x1007 over 8 acks; req low the cycle after the 8th ack.
REQ-027 SHALL cover: 3 pixels 0xAAAA, then in_hs -> flush burst 0xAAAA x3 followed by 0x0000 x5; next burst on row +1, col 0.
REQ-028 SHALL cover: acks withheld while 17 pixels arrive -> 17th word dropped, ovf = 1, ovf_cnt = 1 (macro on).
REQ-029 SHALL cover: out_hs with out_row 7, out_width 20 -> 3 bursts at col 0, 8, 16; 24 lb_we pulses at lb_addr 0..23.
REQ-030 SHALL cover: in_vs twice, then out_hs -> vidout_frame = 1 while vidin_frame = 2.
REQ-031 SHALL cover: init_n low mid-burst after 4 acks -> vidin_req = 0 immediately; no vidin_req after release until new pixels arrive.
